// File: rtl/otter_crypto_pkg.sv
// Shared types and round helpers for the OTTER ENCRY Feistel engine.
package otter_crypto_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} crypto_state_t;

   localparam logic CRYPTO_MODE_ENC = 1'b0;
   localparam logic CRYPTO_MODE_DEC = 1'b1;

   // Rotation amount 4*j mod 32 only depends on j[2:0]; j[3] still enters the XOR term.
   function automatic logic [15:0] crypto_round_key(input logic [31:0] key, input logic [3:0] j);
      logic [4:0]  sh;
      logic [63:0] dbl;
      sh  = {j[2:0], 2'b00};
      dbl = {key, key} << sh;
      return dbl[47:32] ^ {12'h000, j};
   endfunction

   function automatic logic [15:0] crypto_f(input logic [15:0] r, input logic [15:0] k);
      logic [15:0] rot;
      rot = {r[10:0], r[15:11]};
      return (rot + k) ^ (r >> 3);
   endfunction

endpackage

// File: rtl/otter_crypto_round.sv
// One combinational Feistel round: L' = R, R' = L ^ F(R, K).
module otter_crypto_round
   import otter_crypto_pkg::*;
(
   input  logic [15:0] l,
   input  logic [15:0] r,
   input  logic [15:0] k,
   output logic [15:0] l_next,
   output logic [15:0] r_next
);

   assign l_next = r;
   assign r_next = l ^ crypto_f(r, k);

endmodule

// File: rtl/otter_crypto_unit.sv
// Multi-cycle Feistel engine for the ENCRY instruction, one round per clock.
// Optional CRYPTO_ABORT port is enabled by defining OTTER_CRYPTO_ABORT_EN.
module otter_crypto_unit
   import otter_crypto_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CRYPTO_START,
   input  logic        CRYPTO_SEL,
   input  logic [31:0] CRYPTO_DATA,
   input  logic [31:0] CRYPTO_KEY,
`ifdef OTTER_CRYPTO_ABORT_EN
   input  logic        CRYPTO_ABORT,
`endif
   output logic        CRYPTO_BUSY,
   output logic        CRYPTO_DONE,
   output logic [31:0] CRYPTO_RESULT
);

   localparam logic [4:0] LAST_RND = 5'(NUM_ROUNDS - 1);

   crypto_state_t state;
   logic [15:0]   l_q, r_q;
   logic [31:0]   key_q;
   logic          mode_q;
   logic [4:0]    rnd;
   logic [3:0]    j;
   logic [15:0]   rk;
   logic [15:0]   l_next, r_next;

   // Decrypt walks the key schedule backwards.
   always_comb begin
      j = rnd[3:0];
      if (mode_q == CRYPTO_MODE_DEC)
         j = 4'(LAST_RND - rnd);
      rk = crypto_round_key(key_q, j);
   end

   otter_crypto_round u_round (
      .l      (l_q),
      .r      (r_q),
      .k      (rk),
      .l_next (l_next),
      .r_next (r_next)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         l_q           <= '0;
         r_q           <= '0;
         key_q         <= '0;
         mode_q        <= CRYPTO_MODE_ENC;
         rnd           <= '0;
         CRYPTO_BUSY   <= 1'b0;
         CRYPTO_DONE   <= 1'b0;
         CRYPTO_RESULT <= '0;
      end else begin
         case (state)
            IDLE: begin
               CRYPTO_DONE <= 1'b0;
               if (CRYPTO_START) begin
                  l_q         <= CRYPTO_DATA[31:16];
                  r_q         <= CRYPTO_DATA[15:0];
                  key_q       <= CRYPTO_KEY;
                  mode_q      <= CRYPTO_SEL;
                  rnd         <= '0;
                  state       <= RUN;
                  CRYPTO_BUSY <= 1'b1;
               end
            end
            RUN: begin
`ifdef OTTER_CRYPTO_ABORT_EN
               if (CRYPTO_ABORT) begin
                  state       <= IDLE;
                  CRYPTO_BUSY <= 1'b0;
               end else
`endif
               begin
                  l_q <= l_next;
                  r_q <= r_next;
                  rnd <= rnd + 5'd1;
                  if (rnd == LAST_RND) begin
                     state         <= DONE;
                     CRYPTO_RESULT <= {r_next, l_next};
                     CRYPTO_DONE   <= 1'b1;
                  end
               end
            end
            DONE: begin
               state       <= IDLE;
               CRYPTO_DONE <= 1'b0;
               CRYPTO_BUSY <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               CRYPTO_DONE <= 1'b0;
               CRYPTO_BUSY <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_otter_crypto_unit.sv
// Directed bench for otter_crypto_unit at NUM_ROUNDS 8, 1 and 16.
// Abort checks are included when OTTER_CRYPTO_ABORT_EN is defined.
module tb_otter_crypto_unit;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   logic a_start, a_sel, a_busy, a_done;
   logic [31:0] a_data, a_key, a_result;
   logic b_start, b_sel, b_busy, b_done;
   logic [31:0] b_data, b_key, b_result;
   logic c_start, c_sel, c_busy, c_done;
   logic [31:0] c_data, c_key, c_result;
`ifdef OTTER_CRYPTO_ABORT_EN
   logic a_abort, b_abort, c_abort;
`endif

   always #5 clk = ~clk;

   otter_crypto_unit #(.NUM_ROUNDS(8)) dut_a (
      .CLK(clk), .RST(rst), .CRYPTO_START(a_start), .CRYPTO_SEL(a_sel),
      .CRYPTO_DATA(a_data), .CRYPTO_KEY(a_key),
`ifdef OTTER_CRYPTO_ABORT_EN
      .CRYPTO_ABORT(a_abort),
`endif
      .CRYPTO_BUSY(a_busy), .CRYPTO_DONE(a_done), .CRYPTO_RESULT(a_result));

   otter_crypto_unit #(.NUM_ROUNDS(1)) dut_b (
      .CLK(clk), .RST(rst), .CRYPTO_START(b_start), .CRYPTO_SEL(b_sel),
      .CRYPTO_DATA(b_data), .CRYPTO_KEY(b_key),
`ifdef OTTER_CRYPTO_ABORT_EN
      .CRYPTO_ABORT(b_abort),
`endif
      .CRYPTO_BUSY(b_busy), .CRYPTO_DONE(b_done), .CRYPTO_RESULT(b_result));

   otter_crypto_unit #(.NUM_ROUNDS(16)) dut_c (
      .CLK(clk), .RST(rst), .CRYPTO_START(c_start), .CRYPTO_SEL(c_sel),
      .CRYPTO_DATA(c_data), .CRYPTO_KEY(c_key),
`ifdef OTTER_CRYPTO_ABORT_EN
      .CRYPTO_ABORT(c_abort),
`endif
      .CRYPTO_BUSY(c_busy), .CRYPTO_DONE(c_done), .CRYPTO_RESULT(c_result));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Independent cipher model written straight from the algorithm description.
   function automatic logic [31:0] model(input int unsigned nr, input logic sel,
                                         input logic [31:0] d, input logic [31:0] k);
      logic [15:0] l, r, t, rk, rr, f;
      logic [31:0] rot;
      int unsigned jj, s;
      l = d[31:16];
      r = d[15:0];
      for (int unsigned i = 0; i < nr; i++) begin
         jj  = sel ? (nr - 1 - i) : i;
         s   = (4 * jj) % 32;
         rot = (s == 0) ? k : ((k << s) | (k >> (32 - s)));
         rk  = rot[15:0] ^ 16'(jj & 15);
         rr  = (r << 5) | (r >> 11);
         f   = (rr + rk) ^ (r >> 3);
         t   = r;
         r   = l ^ f;
         l   = t;
      end
      return {r, l};
   endfunction

   task automatic drive(input int unsigned which, input logic st, input logic sel,
                        input logic [31:0] d, input logic [31:0] k);
      case (which)
         0: begin a_start = st; a_sel = sel; a_data = d; a_key = k; end
         1: begin b_start = st; b_sel = sel; b_data = d; b_key = k; end
         default: begin c_start = st; c_sel = sel; c_data = d; c_key = k; end
      endcase
   endtask

   // Latency counts the start edge as cycle 1; the call returns with the DUT back in IDLE.
   task automatic run_op(input int unsigned which, input logic sel, input logic [31:0] d,
                         input logic [31:0] k, output logic [31:0] res, output int unsigned lat);
      logic dn;
      @(negedge clk);
      drive(which, 1'b1, sel, d, k);
      @(posedge clk);
      #1 drive(which, 1'b0, ~sel, ~d, ~k);
      lat = 0;
      dn  = 1'b0;
      res = '0;
      while (!dn && lat < 40) begin
         lat++;
         @(negedge clk);
         case (which)
            0: begin dn = a_done; res = a_result; end
            1: begin dn = b_done; res = b_result; end
            default: begin dn = c_done; res = c_result; end
         endcase
         if (!dn) @(posedge clk);
      end
      if (!dn) check("done_timeout", 32'(dn), 32'd1);
      @(posedge clk);
   endtask

   initial begin
      logic [31:0] res, enc, d1, d3, enc00, d, k;
      int unsigned lat;

      // Reset held with START asserted.
      rst = 1'b1;
      drive(0, 1'b1, 1'b0, 32'h11112222, 32'h33334444);
      drive(1, 1'b0, 1'b0, '0, '0);
      drive(2, 1'b0, 1'b0, '0, '0);
`ifdef OTTER_CRYPTO_ABORT_EN
      a_abort = 1'b0; b_abort = 1'b0; c_abort = 1'b0;
`endif
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         check("rst_busy", 32'(a_busy), 32'd0);
         check("rst_done", 32'(a_done), 32'd0);
         check("rst_result", a_result, 32'h0);
      end
      rst = 1'b0;
      a_start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_busy", 32'(a_busy), 32'd0);

      // Round trip at 8 rounds.
      run_op(0, 1'b0, 32'hDEADBEEF, 32'h0F1E2D3C, enc, lat);
      check("enc_latency", lat, 32'd9);
      check("enc_result", enc, model(8, 1'b0, 32'hDEADBEEF, 32'h0F1E2D3C));
      run_op(0, 1'b1, enc, 32'h0F1E2D3C, res, lat);
      check("dec_latency", lat, 32'd9);
      check("dec_result", res, 32'hDEADBEEF);

      // Starts during RUN and DONE are dropped; the first IDLE start is taken.
      d1 = 32'hCAFEF00D;
      d3 = 32'h0BADC0DE;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, d1, 32'h13579BDF);
      @(posedge clk);
      #1 a_start = 1'b0;
      @(negedge clk);
      for (int e = 1; e <= 18; e++) begin
         a_start = (e == 3 || e == 9 || e == 10);
         a_data  = (e == 10) ? d3 : 32'h12345678;
         @(posedge clk);
         #1 a_start = 1'b0;
         @(negedge clk);
         check($sformatf("busy_e%0d", e), 32'(a_busy), 32'(e != 9));
         check($sformatf("done_e%0d", e), 32'(a_done), 32'(e == 8 || e == 18));
         if (e == 8 || e == 10)
            check($sformatf("first_result_e%0d", e), a_result, model(8, 1'b0, d1, 32'h13579BDF));
         if (e == 18)
            check("third_result", a_result, model(8, 1'b0, d3, 32'h13579BDF));
      end
      @(posedge clk);

      // Reset during the fourth RUN cycle.
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'h55AA55AA, 32'hFFFF0000);
      @(posedge clk);
      #1 a_start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(a_busy), 32'd0);
      check("midrst_done", 32'(a_done), 32'd0);
      check("midrst_result", a_result, 32'h0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("midrst_no_done", 32'(a_done), 32'd0);
      end
      enc00 = model(8, 1'b0, 32'h0, 32'h0);
      run_op(0, 1'b0, 32'h0, 32'h0, res, lat);
      check("zero_latency", lat, 32'd9);
      check("zero_result", res, enc00);

      // Single-round hand vectors.
      run_op(1, 1'b0, 32'h00000001, 32'h0, res, lat);
      check("nr1_latency", lat, 32'd2);
      check("nr1_vec_a", res, 32'h00200001);
      run_op(1, 1'b0, 32'h00000008, 32'h00000005, res, lat);
      check("nr1_vec_b", res, 32'h01040008);
      run_op(2, 1'b0, 32'hDEADBEEF, 32'h0F1E2D3C, res, lat);
      check("nr16_latency", lat, 32'd17);
      check("nr16_result", res, model(16, 1'b0, 32'hDEADBEEF, 32'h0F1E2D3C));

      // Random round trips at 1 and 16 rounds.
      for (int i = 0; i < 1000; i++) begin
         d = $urandom;
         k = $urandom;
         run_op(1, 1'b0, d, k, enc, lat);
         check("sw1_enc", enc, model(1, 1'b0, d, k));
         run_op(1, 1'b1, enc, k, res, lat);
         check("sw1_rt", res, d);
         run_op(2, 1'b0, d, k, enc, lat);
         check("sw16_enc", enc, model(16, 1'b0, d, k));
         run_op(2, 1'b1, enc, k, res, lat);
         check("sw16_rt", res, d);
      end

`ifdef OTTER_CRYPTO_ABORT_EN
      // Abort at the fifth RUN edge leaves the previous result in place.
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'h87654321, 32'h1);
      @(posedge clk);
      #1 a_start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      a_abort = 1'b1;
      @(posedge clk);
      #1 a_abort = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(a_busy), 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("abort_no_done", 32'(a_done), 32'd0);
         check("abort_result", a_result, enc00);
      end
      // ABORT together with START in IDLE: the operation runs.
      drive(0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0F1E2D3C);
      a_abort = 1'b1;
      @(posedge clk);
      #1 begin a_start = 1'b0; a_abort = 1'b0; end
      @(negedge clk);
      check("abort_start_busy", 32'(a_busy), 32'd1);
      lat = 1;
      while (!a_done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("abort_start_latency", lat, 32'd9);
      check("abort_start_result", a_result, model(8, 1'b0, 32'hDEADBEEF, 32'h0F1E2D3C));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
